dla_regif_ape_cmdq: RTL and testbench



---
 rtl/dla_regif_ape_cmdq.sv | 197 +++++++++++++++++++
 tb/tb_dla_regif_ape_cmdq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_regif_ape_cmdq.sv
// rtl/dla_regif_ape_cmdq.sv - APE descriptor register interface and command FIFO
//
// Software writes the SRC/DEST/IMM/CTRL registers. Every CTRL write with
// GO (bit 31) set pushes one descriptor into a DEPTH-entry show-ahead FIFO.
// The APE engine drains the FIFO over a valid/ready handshake and signals
// completion with ape_done. The block also tracks fill level, outstanding
// jobs, idle status and sticky error flags (write-1-to-clear through STAT).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ape_*_wen, regif_wdata         register write strobes and write data
//   ape_*_rdata                    combinational register read data
//   cmd_valid / cmd_ready          descriptor handshake toward the engine
//   cmd_gb_addr_sa/sb/d, cmd_len,
//   cmd_imm, cmd_mode              descriptor at the FIFO head
//   ape_done                       one pulse per completed descriptor
//   ape_idle                       FIFO empty and nothing outstanding

package dla_regif_ape_cmdq_pkg;
  typedef enum logic [2:0] {
    APE_ELEADD  = 3'd0,
    APE_ELEMUL  = 3'd1,
    APE_IMMADD  = 3'd2,
    APE_IMMMUL  = 3'd3,
    APE_ACTFUNC = 3'd4
  } ape_mode_e;
endpackage

module dla_regif_ape_cmdq
  import dla_regif_ape_cmdq_pkg::*;
#(
  parameter int AW    = 13,
  parameter int LW    = 13,
  parameter int IW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ape_src_wen,
  input  logic          ape_dest_wen,
  input  logic          ape_imm_wen,
  input  logic          ape_ctrl_wen,
  input  logic          ape_stat_wen,
  input  logic [31:0]   regif_wdata,
  output logic [31:0]   ape_src_rdata,
  output logic [31:0]   ape_dest_rdata,
  output logic [31:0]   ape_imm_rdata,
  output logic [31:0]   ape_ctrl_rdata,
  output logic [31:0]   ape_stat_rdata,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW-1:0] cmd_gb_addr_sa,
  output logic [AW-1:0] cmd_gb_addr_sb,
  output logic [AW-1:0] cmd_gb_addr_d,
  output logic [LW-1:0] cmd_len,
  output logic [IW-1:0] cmd_imm,
  output ape_mode_e     cmd_mode,
  input  logic          ape_done,
  output logic          ape_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  // Configuration registers
  logic [AW-1:0] sa_q, sb_q, d_q;
  logic [LW-1:0] len_q;
  logic [IW-1:0] imm_q;
  logic [2:0]    mode_q;

  // FIFO storage, one array per descriptor field
  logic [AW-1:0] fifo_sa   [DEPTH];
  logic [AW-1:0] fifo_sb   [DEPTH];
  logic [AW-1:0] fifo_d    [DEPTH];
  logic [LW-1:0] fifo_len  [DEPTH];
  logic [IW-1:0] fifo_imm  [DEPTH];
  logic [2:0]    fifo_mode [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [PW:0]   fill;
  logic [PW-1:0] rd_idx, wr_idx;

  logic [7:0] outstanding;
  logic       err_ovf, err_mode, err_done;

  logic empty, full, pop, go, mode_ok, push;
  logic ovf_evt, mode_evt, done_evt;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fill   = wr_ptr - rd_ptr;
  assign rd_idx = rd_ptr[PW-1:0];
  assign wr_idx = wr_ptr[PW-1:0];

  assign cmd_valid = ~empty;
  assign pop       = cmd_valid & cmd_ready;
  assign go        = ape_ctrl_wen & regif_wdata[31];
  assign mode_ok   = (regif_wdata[2:0] <= 3'd4);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = go & mode_ok & (~full | pop);
  assign ovf_evt  = go & mode_ok & full & ~pop;
  assign mode_evt = go & ~mode_ok;
  // A pop in the same cycle pairs with the done, so it is never an error
  assign done_evt = ape_done & ~pop & (outstanding == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      d_q    <= '0;
      len_q  <= '0;
      imm_q  <= '0;
      mode_q <= '0;
    end else begin
      if (ape_src_wen) begin
        sa_q <= regif_wdata[AW-1:0];
        sb_q <= regif_wdata[AW+15:16];
      end
      if (ape_dest_wen) begin
        d_q   <= regif_wdata[AW-1:0];
        len_q <= regif_wdata[LW+15:16];
      end
      if (ape_imm_wen) imm_q <= regif_wdata[IW-1:0];
      if (ape_ctrl_wen) mode_q <= mode_ok ? regif_wdata[2:0] : 3'd0;
    end
  end

  // The pushed payload uses the register values from before this edge, so a
  // config write in the GO cycle only affects the next descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_sa[i]   <= '0;
        fifo_sb[i]   <= '0;
        fifo_d[i]    <= '0;
        fifo_len[i]  <= '0;
        fifo_imm[i]  <= '0;
        fifo_mode[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_sa[wr_idx]   <= sa_q;
        fifo_sb[wr_idx]   <= sb_q;
        fifo_d[wr_idx]    <= d_q;
        fifo_len[wr_idx]  <= len_q;
        fifo_imm[wr_idx]  <= imm_q;
        fifo_mode[wr_idx] <= regif_wdata[2:0];
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      err_ovf     <= 1'b0;
      err_mode    <= 1'b0;
      err_done    <= 1'b0;
    end else begin
      if (pop && !ape_done) begin
        if (outstanding != 8'hFF) outstanding <= outstanding + 8'd1;
      end else if (ape_done && !pop && outstanding != 8'd0) begin
        outstanding <= outstanding - 8'd1;
      end
      // A set event in the clear cycle keeps the flag set
      err_ovf  <= ovf_evt  | (err_ovf  & ~(ape_stat_wen & regif_wdata[24]));
      err_mode <= mode_evt | (err_mode & ~(ape_stat_wen & regif_wdata[25]));
      err_done <= done_evt | (err_done & ~(ape_stat_wen & regif_wdata[26]));
    end
  end

  assign cmd_gb_addr_sa = fifo_sa[rd_idx];
  assign cmd_gb_addr_sb = fifo_sb[rd_idx];
  assign cmd_gb_addr_d  = fifo_d[rd_idx];
  assign cmd_len        = fifo_len[rd_idx];
  assign cmd_imm        = fifo_imm[rd_idx];
  assign cmd_mode       = ape_mode_e'(fifo_mode[rd_idx]);

  assign ape_idle = empty & (outstanding == 8'd0);

  assign ape_src_rdata  = {16'(sb_q), 16'(sa_q)};
  assign ape_dest_rdata = {16'(len_q), 16'(d_q)};
  assign ape_imm_rdata  = 32'(imm_q);
  assign ape_ctrl_rdata = {29'd0, mode_q};
  assign ape_stat_rdata = {ape_idle, 4'd0, err_done, err_mode, err_ovf, 6'd0,
                           empty, full, outstanding, 8'(fill)};

  // Write-data bits outside every register field are intentionally ignored
  logic unused_wdata;
  assign unused_wdata = ^regif_wdata;

endmodule

// File: tb/tb_dla_regif_ape_cmdq.sv
// tb/tb_dla_regif_ape_cmdq.sv - self-checking bench for dla_regif_ape_cmdq
module tb_dla_regif_ape_cmdq;
  import dla_regif_ape_cmdq_pkg::*;

  localparam int AW = 13;
  localparam int LW = 13;
  localparam int IW = 16;
  localparam int DEPTH = 4;
  localparam int R_SRC = 0, R_DEST = 1, R_IMM = 2, R_CTRL = 3, R_STAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ape_src_wen, ape_dest_wen, ape_imm_wen, ape_ctrl_wen, ape_stat_wen;
  logic [31:0] regif_wdata;
  logic [31:0] ape_src_rdata, ape_dest_rdata, ape_imm_rdata, ape_ctrl_rdata, ape_stat_rdata;
  logic cmd_valid, cmd_ready, ape_done, ape_idle;
  logic [AW-1:0] cmd_gb_addr_sa, cmd_gb_addr_sb, cmd_gb_addr_d;
  logic [LW-1:0] cmd_len;
  logic [IW-1:0] cmd_imm;
  ape_mode_e cmd_mode;

  dla_regif_ape_cmdq #(.AW(AW), .LW(LW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ape_src_wen(ape_src_wen), .ape_dest_wen(ape_dest_wen), .ape_imm_wen(ape_imm_wen),
    .ape_ctrl_wen(ape_ctrl_wen), .ape_stat_wen(ape_stat_wen), .regif_wdata(regif_wdata),
    .ape_src_rdata(ape_src_rdata), .ape_dest_rdata(ape_dest_rdata), .ape_imm_rdata(ape_imm_rdata),
    .ape_ctrl_rdata(ape_ctrl_rdata), .ape_stat_rdata(ape_stat_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_gb_addr_sa(cmd_gb_addr_sa), .cmd_gb_addr_sb(cmd_gb_addr_sb), .cmd_gb_addr_d(cmd_gb_addr_d),
    .cmd_len(cmd_len), .cmd_imm(cmd_imm), .cmd_mode(cmd_mode),
    .ape_done(ape_done), .ape_idle(ape_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sa, sb, d, len, imm, mode;
  } desc_t;

  desc_t q[$];
  int unsigned m_sa, m_sb, m_d, m_len, m_imm, m_mode, m_out;
  bit m_eo, m_em, m_ed;
  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  localparam int unsigned AMASK = (1 << AW) - 1;
  localparam int unsigned LMASK = (1 << LW) - 1;
  localparam int unsigned IMASK = (1 << IW) - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_sa = 0; m_sb = 0; m_d = 0; m_len = 0; m_imm = 0; m_mode = 0; m_out = 0;
    m_eo = 0; m_em = 0; m_ed = 0;
  endfunction

  // One clock of queue-level behaviour, from the inputs seen at the edge
  function automatic void model_step(input bit sw, input bit dw, input bit iw, input bit cw,
                                     input bit stw, input logic [31:0] wd,
                                     input bit rdy, input bit dn);
    bit pop, was_full, go, so, sm, sd;
    desc_t nd;
    pop = rdy && (q.size() != 0);
    was_full = (q.size() == DEPTH);
    go = cw && wd[31];
    so = 0; sm = 0; sd = 0;
    if (pop) void'(q.pop_front());
    if (pop && !dn) m_out = (m_out == 255) ? 255 : m_out + 1;
    else if (dn && !pop) begin
      if (m_out == 0) sd = 1;
      else m_out = m_out - 1;
    end
    if (go) begin
      if (wd[2:0] > 3'd4) sm = 1;
      else if (was_full && !pop) so = 1;
      else begin
        nd.sa = m_sa; nd.sb = m_sb; nd.d = m_d; nd.len = m_len; nd.imm = m_imm;
        nd.mode = wd[2:0];
        q.push_back(nd);
      end
    end
    if (sw) begin m_sa = wd & AMASK; m_sb = (wd >> 16) & AMASK; end
    if (dw) begin m_d = wd & AMASK; m_len = (wd >> 16) & LMASK; end
    if (iw) m_imm = wd & IMASK;
    if (cw) m_mode = (wd[2:0] > 3'd4) ? 0 : wd[2:0];
    m_eo = so || (m_eo && !(stw && wd[24]));
    m_em = sm || (m_em && !(stw && wd[25]));
    m_ed = sd || (m_ed && !(stw && wd[26]));
  endfunction

  function automatic logic [31:0] exp_stat();
    logic [31:0] s;
    int unsigned n;
    n = q.size();
    s = 32'(n) | (32'(m_out) << 8);
    s[16] = (n == DEPTH);
    s[17] = (n == 0);
    s[24] = m_eo;
    s[25] = m_em;
    s[26] = m_ed;
    s[31] = (n == 0) && (m_out == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cmd_valid", 32'(cmd_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("head_sa", 32'(cmd_gb_addr_sa), q[0].sa);
        chk("head_sb", 32'(cmd_gb_addr_sb), q[0].sb);
        chk("head_d", 32'(cmd_gb_addr_d), q[0].d);
        chk("head_len", 32'(cmd_len), q[0].len);
        chk("head_imm", 32'(cmd_imm), q[0].imm);
        chk("head_mode", 32'(cmd_mode), q[0].mode);
      end
      chk("stat", ape_stat_rdata, exp_stat());
      chk("idle", 32'(ape_idle), 32'((q.size() == 0) && (m_out == 0)));
      chk("src_rd", ape_src_rdata, (m_sb << 16) | m_sa);
      chk("dest_rd", ape_dest_rdata, (m_len << 16) | m_d);
      chk("imm_rd", ape_imm_rdata, m_imm);
      chk("ctrl_rd", ape_ctrl_rdata, m_mode);
    end
  end

  task automatic tick();
    bit sw = ape_src_wen, dw = ape_dest_wen, iw = ape_imm_wen;
    bit cw = ape_ctrl_wen, stw = ape_stat_wen;
    logic [31:0] wd = regif_wdata;
    bit rdy = cmd_ready, dn = ape_done;
    @(posedge clk);
    model_step(sw, dw, iw, cw, stw, wd, rdy, dn);
    #1;
    ape_src_wen = 0; ape_dest_wen = 0; ape_imm_wen = 0; ape_ctrl_wen = 0; ape_stat_wen = 0;
    ape_done = 0;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    regif_wdata = d;
    case (r)
      R_SRC:  ape_src_wen = 1;
      R_DEST: ape_dest_wen = 1;
      R_IMM:  ape_imm_wen = 1;
      R_CTRL: ape_ctrl_wen = 1;
      default: ape_stat_wen = 1;
    endcase
    tick();
  endtask

  initial begin
    ape_src_wen = 0; ape_dest_wen = 0; ape_imm_wen = 0; ape_ctrl_wen = 0; ape_stat_wen = 0;
    regif_wdata = 0; cmd_ready = 0; ape_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    cmp_en = 1;

    chk("rst_stat", ape_stat_rdata, 32'h8002_0000);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_idle", 32'(ape_idle), 1);
    chk("rst_mode", 32'(cmd_mode), 0);
    chk("rst_src", ape_src_rdata, 0);

    // Single push
    wr(R_SRC, 32'h0010_0020);
    wr(R_DEST, 32'h0008_0040);
    wr(R_IMM, 32'h0000_1234);
    chk("src_readback", ape_src_rdata, 32'h0010_0020);
    wr(R_CTRL, 32'h8000_0002);
    chk("p1_valid", 32'(cmd_valid), 1);
    chk("p1_sa", 32'(cmd_gb_addr_sa), 32'h20);
    chk("p1_sb", 32'(cmd_gb_addr_sb), 32'h10);
    chk("p1_d", 32'(cmd_gb_addr_d), 32'h40);
    chk("p1_len", 32'(cmd_len), 8);
    chk("p1_imm", 32'(cmd_imm), 32'h1234);
    chk("p1_mode", 32'(cmd_mode), 32'(APE_IMMADD));
    chk("p1_fill", 32'(ape_stat_rdata[7:0]), 1);
    chk("p1_model_fill", q.size(), 1);

    // Fill, then overflow
    wr(R_CTRL, 32'h8000_0000);
    wr(R_SRC, 32'h0003_0004);
    wr(R_CTRL, 32'h8000_0001);
    wr(R_CTRL, 32'h8000_0004);
    chk("fill_full", 32'(ape_stat_rdata[16]), 1);
    wr(R_CTRL, 32'h8000_0003);
    chk("ovf_flag", 32'(ape_stat_rdata[24]), 1);
    chk("ovf_fill", 32'(ape_stat_rdata[7:0]), 4);
    wr(R_STAT, 32'h0100_0000);
    chk("ovf_clear", 32'(ape_stat_rdata[24]), 0);

    // Push and pop together while full, wrapping the pointers
    cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      ape_imm_wen = 1;
      ape_ctrl_wen = 1;
      regif_wdata = 32'h8000_0000 | 32'(i);
      tick();
    end
    chk("pp_fill", 32'(ape_stat_rdata[7:0]), 4);
    chk("pp_no_ovf", 32'(ape_stat_rdata[24]), 0);
    repeat (4) tick();
    cmd_ready = 0;
    chk("drain_valid", 32'(cmd_valid), 0);
    chk("drain_outst", 32'(ape_stat_rdata[15:8]), 8);
    repeat (8) begin
      ape_done = 1;
      tick();
    end
    chk("drain_idle", 32'(ape_idle), 1);

    // Invalid mode, and set winning over clear
    wr(R_CTRL, 32'h8000_0006);
    chk("bad_ctrl_rd", ape_ctrl_rdata, 0);
    chk("bad_err_mode", 32'(ape_stat_rdata[25]), 1);
    chk("bad_no_push", 32'(cmd_valid), 0);
    ape_stat_wen = 1;
    ape_ctrl_wen = 1;
    regif_wdata = 32'h8200_0007;
    tick();
    chk("set_wins", 32'(ape_stat_rdata[25]), 1);
    wr(R_STAT, 32'h0200_0000);
    chk("mode_clear", 32'(ape_stat_rdata[25]), 0);
    wr(R_CTRL, 32'h0000_0004);
    chk("ctrl_nogo_rd", ape_ctrl_rdata, 4);
    chk("ctrl_nogo_valid", 32'(cmd_valid), 0);

    // Done tracking with one coinciding pop and done
    repeat (3) wr(R_CTRL, 32'h8000_0001);
    cmd_ready = 1;
    tick();
    ape_done = 1;
    tick();
    tick();
    cmd_ready = 0;
    chk("done_outst2", 32'(ape_stat_rdata[15:8]), 2);
    ape_done = 1; tick();
    ape_done = 1; tick();
    chk("done_idle", 32'(ape_idle), 1);
    ape_done = 1; tick();
    chk("done_err", 32'(ape_stat_rdata[26]), 1);
    chk("done_outst0", 32'(ape_stat_rdata[15:8]), 0);
    wr(R_STAT, 32'h0400_0000);

    // SRC write in the GO cycle
    wr(R_SRC, 32'h0001_0002);
    ape_src_wen = 1;
    ape_ctrl_wen = 1;
    regif_wdata = 32'h8005_0001;
    tick();
    wr(R_CTRL, 32'h8000_0003);
    chk("same_sa_old", 32'(cmd_gb_addr_sa), 2);
    chk("same_sb_old", 32'(cmd_gb_addr_sb), 1);
    chk("same_fill", 32'(ape_stat_rdata[7:0]), 2);
    chk("same_src_rd", ape_src_rdata, 32'h0005_0001);
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    chk("same_sa_new", 32'(cmd_gb_addr_sa), 1);
    chk("same_sb_new", 32'(cmd_gb_addr_sb), 5);
    chk("same_mode_new", 32'(cmd_mode), 32'(APE_IMMMUL));

    // Asynchronous reset with a descriptor queued
    #1;
    rst = 1;
    #1;
    chk("async_valid", 32'(cmd_valid), 0);
    chk("async_stat", ape_stat_rdata, 32'h8002_0000);
    chk("async_src", ape_src_rdata, 0);
    model_reset();
    #1;
    rst = 0;
    repeat (2) tick();

    // Outstanding saturation
    cmd_ready = 1;
    repeat (260) begin
      ape_ctrl_wen = 1;
      regif_wdata = 32'h8000_0000;
      tick();
    end
    cmd_ready = 0;
    tick();
    chk("sat_outst", 32'(ape_stat_rdata[15:8]), 255);
    ape_done = 1;
    tick();
    chk("sat_dec", 32'(ape_stat_rdata[15:8]), 254);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
